// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag-vector layout for the pipelined ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  // Flag vector is packed as {S, ZR, CY, P, V}
  localparam int NFLAGS = 5;
  localparam int S  = 4;
  localparam int ZR = 3;
  localparam int CY = 2;
  localparam int P  = 1;
  localparam int V  = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and flags from op, operands and carry-in.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]        op_i,
  input  logic [WIDTH-1:0]  x_i,
  input  logic [WIDTH-1:0]  y_i,
  input  logic              cin_i,
  output logic [WIDTH-1:0]  z_o,
  output logic [NFLAGS-1:0] flags_o
);

  function automatic logic even_parity(input logic [WIDTH-1:0] val);
    return ~^val;
  endfunction

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] zc;
  logic             is_sub;
  logic             is_arith;
  logic             x_msb, y_msb, z_msb;

  // WIDTH+1-bit arithmetic: the top bit is carry for adds and borrow for subtracts
  always_comb begin
    wide     = '0;
    is_sub   = 1'b0;
    is_arith = 1'b1;
    case (op_i)
      OP_ADD: wide = {1'b0, x_i} + {1'b0, y_i};
      OP_ADC: wide = {1'b0, x_i} + {1'b0, y_i} + {{WIDTH{1'b0}}, cin_i};
      OP_SUB, OP_CMP: begin
        wide   = {1'b0, x_i} - {1'b0, y_i};
        is_sub = 1'b1;
      end
      OP_SBB: begin
        wide   = {1'b0, x_i} - {1'b0, y_i} - {{WIDTH{1'b0}}, cin_i};
        is_sub = 1'b1;
      end
      OP_AND: begin
        wide     = {1'b0, x_i & y_i};
        is_arith = 1'b0;
      end
      OP_OR: begin
        wide     = {1'b0, x_i | y_i};
        is_arith = 1'b0;
      end
      OP_XOR: begin
        wide     = {1'b0, x_i ^ y_i};
        is_arith = 1'b0;
      end
      default: wide = '0;
    endcase
  end

  assign zc    = wide[WIDTH-1:0];
  assign x_msb = x_i[WIDTH-1];
  assign y_msb = y_i[WIDTH-1];
  assign z_msb = zc[WIDTH-1];

  always_comb begin
    flags_o     = '0;
    flags_o[S]  = z_msb;
    flags_o[ZR] = (zc == '0);
    flags_o[CY] = is_arith & wide[WIDTH];
    flags_o[P]  = even_parity(zc);
    if (is_arith) begin
      if (is_sub) flags_o[V] = (x_msb != y_msb) && (z_msb != x_msb);
      else        flags_o[V] = (x_msb == y_msb) && (z_msb != x_msb);
    end
  end

  // CMP only sets flags; the operand passes through unchanged
  assign z_o = (op_i == OP_CMP) ? x_i : zc;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: operand register, then compute-and-register result/flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             s,
  output logic             zr,
  output logic             cy,
  output logic             p,
  output logic             v
);

  logic              vld_p1_q, vld_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic [2:0]        op_p1_q;
  logic [WIDTH-1:0]  x_p1_q, y_p1_q;
  logic [WIDTH-1:0]  z_p2_q, z_p2_d;
  logic [NFLAGS-1:0] flags_p2_q, flags_p2_d;
  logic              cy_q, cy_d;
  logic [WIDTH-1:0]  core_z;
  logic [NFLAGS-1:0] core_flags;
  logic              s2_adv, s1_move, in_fire;

  assign s2_adv   = !vld_p2_q || out_ready;
  assign s1_move  = vld_p1_q && s2_adv;
  assign in_ready = !vld_p1_q || s2_adv;
  assign in_fire  = in_valid && in_ready;

  // Stage 1 -> stage 2 boundary
  alu_core #(.WIDTH(WIDTH)) u_core (
    .op_i    (op_p1_q),
    .x_i     (x_p1_q),
    .y_i     (y_p1_q),
    .cin_i   (cy_q),
    .z_o     (core_z),
    .flags_o (core_flags)
  );

  always_comb begin
    vld_p1_d   = vld_p1_q;
    vld_p2_d   = vld_p2_q;
    z_p2_d     = z_p2_q;
    flags_p2_d = flags_p2_q;
    cy_d       = cy_q;
    if (s1_move)  vld_p1_d = 1'b0;
    if (in_fire)  vld_p1_d = 1'b1;
    if (out_ready) vld_p2_d = 1'b0;
    if (s1_move) begin
      vld_p2_d   = 1'b1;
      z_p2_d     = core_z;
      flags_p2_d = core_flags;
      cy_d       = core_flags[CY];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      z_p2_q     <= '0;
      flags_p2_q <= '0;
      cy_q       <= 1'b0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      z_p2_q     <= z_p2_d;
      flags_p2_q <= flags_p2_d;
      cy_q       <= cy_d;
    end
  end

  // Input -> stage 1 boundary; operands are qualified by vld_p1_q so need no reset
  always_ff @(posedge clk) begin
    if (in_fire) begin
      op_p1_q <= op;
      x_p1_q  <= x;
      y_p1_q  <= y;
    end
  end

  assign out_valid = vld_p2_q;
  assign z         = z_p2_q;
  assign s         = flags_p2_q[S];
  assign zr        = flags_p2_q[ZR];
  assign cy        = flags_p2_q[CY];
  assign p         = flags_p2_q[P];
  assign v         = flags_p2_q[V];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed ops, backpressure and mid-stream reset.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] x, y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z;
  logic        s, zr, cy, p, v;

  typedef struct packed {
    logic [15:0] z;
    logic [4:0]  f;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .s(s), .zr(zr), .cy(cy), .p(p), .v(v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Drives one op starting at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ez, input logic [4:0] ef);
    int n = 0;
    op = o; x = a; y = b; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end else begin
      exp_q.push_back('{z: ez, f: ef});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: checks each handshaken result against the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out: got z=%h expected no output", z);
        end else begin
          e = exp_q.pop_front();
          chk("out_z", {16'h0, z}, {16'h0, e.z});
          chk("out_flags", {27'h0, s, zr, cy, p, v}, {27'h0, e.f});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; x = 16'h0; y = 16'h0;
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_z", {16'h0, z}, 0);
    chk("rst_flags", {27'h0, s, zr, cy, p, v}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // flags are {s,zr,cy,p,v}
    send(3'b000, 16'h8fff, 16'h8000, 16'h0fff, 5'b00111);
    send(3'b000, 16'h0001, 16'h0002, 16'h0003, 5'b00010);
    send(3'b000, 16'h8000, 16'h8000, 16'h0000, 5'b01111);
    send(3'b001, 16'h0000, 16'h0000, 16'h0001, 5'b00000);
    send(3'b010, 16'h0001, 16'h0002, 16'hffff, 5'b10110);
    send(3'b011, 16'h0005, 16'h0001, 16'h0003, 5'b00010);
    send(3'b111, 16'h7fff, 16'h8000, 16'h7fff, 5'b10111);
    send(3'b110, 16'hffff, 16'hffff, 16'h0000, 5'b01010);
    drain();

    // Backpressure: two ops fill the pipe, third is held off
    out_ready = 1'b0;
    op = 3'b000; x = 16'h0001; y = 16'h0002; in_valid = 1'b1;
    #1;
    chk("bp_ready_a", {31'h0, in_ready}, 1);
    exp_q.push_back('{z: 16'h0003, f: 5'b00010});
    @(negedge clk);
    op = 3'b100; x = 16'hf0f0; y = 16'h0ff0;
    #1;
    chk("bp_ready_b", {31'h0, in_ready}, 1);
    exp_q.push_back('{z: 16'h00f0, f: 5'b00010});
    @(negedge clk);
    op = 3'b101; x = 16'h1200; y = 16'h0034;
    #1;
    chk("bp_ready_c_blocked", {31'h0, in_ready}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("bp_hold_ready", {31'h0, in_ready}, 0);
      chk("bp_hold_valid", {31'h0, out_valid}, 1);
      chk("bp_hold_z", {16'h0, z}, 32'h0003);
      chk("bp_hold_flags", {27'h0, s, zr, cy, p, v}, 32'h02);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_c_release", {31'h0, in_ready}, 1);
    exp_q.push_back('{z: 16'h1234, f: 5'b00000});
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Mid-stream reset with both stages occupied; cy_q holds 1 from the add
    out_ready = 1'b0;
    send(3'b000, 16'h8000, 16'h8000, 16'h0000, 5'b01111);
    send(3'b010, 16'h0001, 16'h0002, 16'hffff, 5'b10110);
    #3;
    chk("full_out_valid", {31'h0, out_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'h0, out_valid}, 0);
    chk("mid_rst_flags", {27'h0, s, zr, cy, p, v}, 0);
    chk("mid_rst_z", {16'h0, z}, 0);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(3'b001, 16'h0001, 16'h0001, 16'h0002, 5'b00000);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
